// File: rtl/ascon_result_serializer.sv
// ascon_result_serializer
// Captures the ASCON ciphertext and tag when the control FSM signals completion.
// It then streams them out as a framed byte sequence over a valid/ready byte
// interface: one sync byte, then the ciphertext bytes, then the tag bytes,
// each block sent in ascending byte order.
// The shadow registers let the FSM start its next operation right after capture.

module ascon_result_serializer #(
  parameter int         CIPHER_BYTES = 184,
  parameter int         TAG_BYTES    = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      done_i,
  input  logic [CIPHER_BYTES*8-1:0] cipher_i,
  input  logic [TAG_BYTES*8-1:0]    tag_i,
  output logic [7:0]                byte_o,
  output logic                      byte_valid_o,
  input  logic                      byte_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      overrun_o
);

  localparam int CIPHER_IW = (CIPHER_BYTES > 1) ? $clog2(CIPHER_BYTES) : 1;
  localparam int TAG_IW    = (TAG_BYTES > 1) ? $clog2(TAG_BYTES) : 1;

  localparam logic [7:0] CIPHER_LAST = 8'(CIPHER_BYTES - 1);
  localparam logic [7:0] TAG_LAST    = 8'(TAG_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    CIPHER,
    TAG,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;
  logic [7:0] index_q;
  logic [7:0] index_d;
  logic capture;
  logic transfer;
  logic overrun_q;

  logic [CIPHER_BYTES-1:0][7:0] cipher_shadow_q;
  logic [TAG_BYTES-1:0][7:0]    tag_shadow_q;

  // A byte moves on any edge where it is offered and the sink is ready.
  assign byte_valid_o = (state_q == HEADER) || (state_q == CIPHER) || (state_q == TAG);
  assign transfer     = byte_valid_o && byte_ready_i;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign overrun_o    = overrun_q;

  // Output byte mux; it is driven only by registers, so it stays stable while the sink stalls.
  always_comb begin
    byte_o = 8'h00;
    case (state_q)
      HEADER:  byte_o = SYNC_BYTE;
      CIPHER:  byte_o = cipher_shadow_q[index_q[CIPHER_IW-1:0]];
      TAG:     byte_o = tag_shadow_q[index_q[TAG_IW-1:0]];
      default: byte_o = 8'h00;
    endcase
  end

  // Frame sequencing: next state, next byte index and capture strobe.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (done_i) begin
          capture = 1'b1;
          index_d = 8'd0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (transfer) begin
          index_d = 8'd0;
          state_d = CIPHER;
        end
      end
      CIPHER: begin
        if (transfer) begin
          if (index_q == CIPHER_LAST) begin
            index_d = 8'd0;
            state_d = TAG;
          end else begin
            index_d = index_q + 8'd1;
          end
        end
      end
      TAG: begin
        if (transfer) begin
          if (index_q == TAG_LAST) begin
            state_d = DONE;
          end else begin
            index_d = index_q + 8'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        index_d = 8'd0;
      end
    endcase
  end

  // State and index registers; a reset mid-frame drops the frame with no resume.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      index_q <= 8'd0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // Shadow copies of the FSM results, loaded only when a frame starts.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cipher_shadow_q <= '0;
      tag_shadow_q    <= '0;
    end else if (capture) begin
      cipher_shadow_q <= cipher_i;
      tag_shadow_q    <= tag_i;
    end
  end

  // Sticky flag: the FSM reported a result while a frame was still in flight.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      overrun_q <= 1'b0;
    end else if (done_i && (state_q != IDLE)) begin
      overrun_q <= 1'b1;
    end
  end

endmodule
